// File: rtl/arcade_inputs.sv
// arcade_inputs: merges PS/2 keys and HPS pads into active-low arcade controls with
// coin pulse shaping and DIP storage. Optional autofire on button 0: ARCADE_INPUTS_AUTOFIRE_EN.
module arcade_inputs #(
    parameter int NUM_PLAYERS     = 2,
    parameter int NUM_BUTTONS     = 4,
    parameter int DIP_BYTES       = 8,
    parameter int COIN_HOLD       = 1600000,
    parameter int AUTOFIRE_PERIOD = 2133333
) (
    input  logic                               CLK_32M,
    input  logic                               reset_n,
    input  logic [10:0]                        ps2_key,
    input  logic [16*NUM_PLAYERS-1:0]          joystick,
    input  logic                               ioctl_wr,
    input  logic [7:0]                         ioctl_index,
    input  logic [24:0]                        ioctl_addr,
    input  logic [7:0]                         ioctl_dout,
    input  logic [NUM_PLAYERS-1:0]             coin_lock,
    input  logic [NUM_PLAYERS-1:0]             autofire_en,
    output logic [4*NUM_PLAYERS-1:0]           p_joystick,
    output logic [NUM_BUTTONS*NUM_PLAYERS-1:0] p_buttons,
    output logic [NUM_PLAYERS-1:0]             start,
    output logic [NUM_PLAYERS-1:0]             coin,
    output logic                               pause,
    output logic [8*DIP_BYTES-1:0]             dip_sw
);

    // Key state bits 0..7 mirror pad bits 0..7 of player 1 so they can be OR-ed directly.
    localparam int K_START1 = 8;
    localparam int K_COIN1  = 9;
    localparam int K_PAUSE  = 10;
    localparam int K_START2 = 11;
    localparam int K_COIN2  = 12;

    localparam int CNT_W = (COIN_HOLD > 0) ? $clog2(COIN_HOLD + 1) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic        ps2_tgl_r;
    logic [12:0] keys_r;
    logic [12:0] key_mask_s;
    logic        key_evt_s;
    logic        pad_pause_s;
    logic        pause_r;
    logic [8*DIP_BYTES-1:0] dip_r = {(8*DIP_BYTES){1'b0}};
    logic        unused_s;

    assign key_evt_s = ps2_key[10] ^ ps2_tgl_r;

    // Scan code to key-state bit decode
    always_comb begin
        key_mask_s = 13'h0000;
        case (ps2_key[7:0])
            8'h74:   key_mask_s = 13'h0001;
            8'h6B:   key_mask_s = 13'h0002;
            8'h72:   key_mask_s = 13'h0004;
            8'h75:   key_mask_s = 13'h0008;
            8'h14:   key_mask_s = 13'h0010;
            8'h11:   key_mask_s = 13'h0020;
            8'h29:   key_mask_s = 13'h0040;
            8'h12:   key_mask_s = 13'h0080;
            8'h16:   key_mask_s = 13'h0100;
            8'h2E:   key_mask_s = 13'h0200;
            8'h4D:   key_mask_s = 13'h0400;
            8'h1E:   key_mask_s = (NUM_PLAYERS > 1) ? 13'h0800 : 13'h0000;
            8'h36:   key_mask_s = (NUM_PLAYERS > 1) ? 13'h1000 : 13'h0000;
            default: key_mask_s = 13'h0000;
        endcase
    end

    // Held-key tracking; the toggle is resynced in reset so no stale event replays
    always_ff @(posedge CLK_32M) begin
        if (!reset_n) begin
            ps2_tgl_r <= ps2_key[10];
            keys_r    <= 13'h0000;
        end else begin
            ps2_tgl_r <= ps2_key[10];
            if (key_evt_s) begin
                keys_r <= ps2_key[9] ? (keys_r | key_mask_s) : (keys_r & ~key_mask_s);
            end
        end
    end

    // Pause request from any pad
    always_comb begin
        pad_pause_s = 1'b0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            pad_pause_s = pad_pause_s | joystick[16*p+14];
        end
    end

    // Pause output register
    always_ff @(posedge CLK_32M) begin
        if (!reset_n) begin
            pause_r <= 1'b0;
        end else begin
            pause_r <= keys_r[K_PAUSE] | pad_pause_s;
        end
    end

    assign pause = pause_r;

    // DIP bytes survive reset so OSD settings persist
    always_ff @(posedge CLK_32M) begin
        if (ioctl_wr && (ioctl_index == 8'd254) && (ioctl_addr < 25'(DIP_BYTES))) begin
            dip_r[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
        end
    end

    assign dip_sw = dip_r;

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        logic [15:0]            key_word_s;
        logic [15:0]            ctl_s;
        logic                   btn0_s;
        logic [NUM_BUTTONS-1:0] btn_s;
        logic [NUM_BUTTONS-1:0] btn_field_s;
        logic [3:0]             joy_r;
        logic [NUM_BUTTONS-1:0] btn_r;
        logic                   start_r;
        logic                   unused_ctl_s;

        // Keyboard contribution laid out in pad-word bit positions
        always_comb begin
            key_word_s = 16'h0000;
            if (p == 0) begin
                key_word_s = {2'b00, keys_r[K_COIN1], keys_r[K_START1], 4'h0, keys_r[7:0]};
            end else if (p == 1) begin
                key_word_s = {2'b00, keys_r[K_COIN2], keys_r[K_START2], 12'h000};
            end else begin
                key_word_s = 16'h0000;
            end
        end

        assign ctl_s        = joystick[16*p +: 16] | key_word_s;
        assign unused_ctl_s = ^ctl_s;

`ifdef ARCADE_INPUTS_AUTOFIRE_EN
        localparam int AF_W = (AUTOFIRE_PERIOD > 1) ? $clog2(AUTOFIRE_PERIOD + 1) : 1;

        logic            af_phase_r;
        logic [AF_W-1:0] af_cnt_r;

        // Autofire phase: asserted half first, cleared whenever the button is released
        always_ff @(posedge CLK_32M) begin
            if (!reset_n) begin
                af_phase_r <= 1'b0;
                af_cnt_r   <= {AF_W{1'b0}};
            end else if (ctl_s[4] && autofire_en[p]) begin
                if (af_cnt_r == AF_W'(AUTOFIRE_PERIOD - 1)) begin
                    af_cnt_r   <= {AF_W{1'b0}};
                    af_phase_r <= ~af_phase_r;
                end else begin
                    af_cnt_r <= af_cnt_r + AF_W'(1);
                end
            end else begin
                af_phase_r <= 1'b0;
                af_cnt_r   <= {AF_W{1'b0}};
            end
        end

        assign btn0_s = ctl_s[4] & ~(autofire_en[p] & af_phase_r);
`else
        assign btn0_s = ctl_s[4];
`endif

        // Button field is reversed so button 0 lands in the MSB
        always_comb begin
            btn_s       = ctl_s[4 +: NUM_BUTTONS];
            btn_s[0]    = btn0_s;
            btn_field_s = {NUM_BUTTONS{1'b1}};
            for (int b = 0; b < NUM_BUTTONS; b++) begin
                btn_field_s[NUM_BUTTONS-1-b] = ~btn_s[b];
            end
        end

        // Active-low control output registers
        always_ff @(posedge CLK_32M) begin
            if (!reset_n) begin
                joy_r   <= 4'hF;
                btn_r   <= {NUM_BUTTONS{1'b1}};
                start_r <= 1'b1;
            end else begin
                joy_r   <= ~ctl_s[3:0];
                btn_r   <= btn_field_s;
                start_r <= ~ctl_s[12];
            end
        end

        assign p_joystick[4*(NUM_PLAYERS-1-p) +: 4]                     = joy_r;
        assign p_buttons[NUM_BUTTONS*(NUM_PLAYERS-1-p) +: NUM_BUTTONS] = btn_r;
        assign start[p]                                                  = start_r;

        if (COIN_HOLD > 0) begin : g_coin
            logic [0:0]       coin_st_r;
            logic [CNT_W-1:0] coin_cnt_r;
            logic             coin_prev_r;
            logic             coin_r;
            logic             coin_rise_s;

            assign coin_rise_s = ctl_s[13] & ~coin_prev_r;

            // Coin pulse FSM: edges seen while holding are dropped, lock only gates new pulses
            always_ff @(posedge CLK_32M) begin
                if (!reset_n) begin
                    coin_st_r   <= ST_IDLE;
                    coin_cnt_r  <= {CNT_W{1'b0}};
                    coin_prev_r <= ctl_s[13];
                    coin_r      <= 1'b1;
                end else begin
                    coin_prev_r <= ctl_s[13];
                    case (coin_st_r)
                        ST_IDLE: begin
                            if (coin_rise_s && !coin_lock[p]) begin
                                coin_st_r  <= ST_HOLD;
                                coin_cnt_r <= CNT_W'(COIN_HOLD);
                                coin_r     <= 1'b0;
                            end
                        end
                        ST_HOLD: begin
                            coin_cnt_r <= coin_cnt_r - CNT_W'(1);
                            if (coin_cnt_r == CNT_W'(1)) begin
                                coin_st_r <= ST_IDLE;
                                coin_r    <= 1'b1;
                            end
                        end
                        default: begin
                            coin_st_r  <= ST_IDLE;
                            coin_cnt_r <= {CNT_W{1'b0}};
                            coin_r     <= 1'b1;
                        end
                    endcase
                end
            end

            assign coin[p] = coin_r;
        end else begin : g_no_coin
            assign coin[p] = 1'b1;
        end
    end

`ifdef ARCADE_INPUTS_AUTOFIRE_EN
    assign unused_s = ^{ps2_key[8], keys_r, coin_lock};
`else
    assign unused_s = ^{ps2_key[8], keys_r, coin_lock, autofire_en};
`endif

endmodule

// File: tb/tb_arcade_inputs.sv
// tb_arcade_inputs: scoreboard bench; a driver pushes model expectations per cycle and a
// monitor pops and compares them after each rising edge.
module tb_arcade_inputs;
    localparam int NP = 2;
    localparam int NB = 4;
    localparam int DB = 8;
    localparam int CH = 10;
    localparam int AP = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [10:0] ps2_key;
    logic [31:0] joystick;
    logic        ioctl_wr;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [1:0]  coin_lock;
    logic [1:0]  autofire_en;
    logic [7:0]  p_joystick;
    logic [7:0]  p_buttons;
    logic [1:0]  start;
    logic [1:0]  coin;
    logic        pause;
    logic [63:0] dip_sw;

    always #5 clk = ~clk;

    arcade_inputs #(
        .NUM_PLAYERS(NP), .NUM_BUTTONS(NB), .DIP_BYTES(DB),
        .COIN_HOLD(CH), .AUTOFIRE_PERIOD(AP)
    ) dut (
        .CLK_32M(clk), .reset_n(reset_n), .ps2_key(ps2_key), .joystick(joystick),
        .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .coin_lock(coin_lock), .autofire_en(autofire_en),
        .p_joystick(p_joystick), .p_buttons(p_buttons), .start(start), .coin(coin),
        .pause(pause), .dip_sw(dip_sw)
    );

    typedef struct {
        logic [7:0]  joy;
        logic [7:0]  btn;
        logic [1:0]  start;
        logic [1:0]  coin;
        logic        pause;
        logic [63:0] dip;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: held keys by scan code, remaining coin-low cycles, autofire hold age
    bit         key_st [256];
    bit         m_tgl;
    int         m_coin_left [2];
    bit         m_coin_high [2];
    bit         m_raw_prev [2];
    int         m_af [2];
    logic [7:0] m_dip [8];

    logic [7:0] codes [15] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h14, 8'h11, 8'h29, 8'h12,
                               8'h16, 8'h2E, 8'h4D, 8'h1E, 8'h36, 8'h55, 8'h33};

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] key_word(int p);
        logic [15:0] w = 16'h0000;
        if (p == 0) begin
            w[0]  = key_st[8'h74];
            w[1]  = key_st[8'h6B];
            w[2]  = key_st[8'h72];
            w[3]  = key_st[8'h75];
            w[4]  = key_st[8'h14];
            w[5]  = key_st[8'h11];
            w[6]  = key_st[8'h29];
            w[7]  = key_st[8'h12];
            w[12] = key_st[8'h16];
            w[13] = key_st[8'h2E];
        end else begin
            w[12] = key_st[8'h1E];
            w[13] = key_st[8'h36];
        end
        return w;
    endfunction

    function automatic void model_step();
        exp_t        e;
        logic [15:0] c [2];
        bit          raw;
        bit          b0;
        for (int p = 0; p < 2; p++) c[p] = joystick[16*p +: 16] | key_word(p);
        if (!reset_n) begin
            e.joy = 8'hFF; e.btn = 8'hFF; e.start = 2'b11; e.coin = 2'b11; e.pause = 1'b0;
            for (int p = 0; p < 2; p++) begin
                m_raw_prev[p]  = c[p][13];
                m_coin_left[p] = 0;
                m_coin_high[p] = 1'b1;
                m_af[p]        = 0;
            end
            for (int k = 0; k < 256; k++) key_st[k] = 1'b0;
            m_tgl = ps2_key[10];
        end else begin
            e.pause = key_st[8'h4D] | joystick[14] | joystick[30];
            for (int p = 0; p < 2; p++) begin
                e.joy[4*(1-p) +: 4] = ~c[p][3:0];
                e.start[p] = ~c[p][12];
                raw = c[p][13];
                if (raw && !m_raw_prev[p] && !coin_lock[p] && m_coin_high[p]) m_coin_left[p] = CH;
                m_raw_prev[p] = raw;
                e.coin[p] = (m_coin_left[p] > 0) ? 1'b0 : 1'b1;
                if (m_coin_left[p] > 0) m_coin_left[p]--;
                m_coin_high[p] = e.coin[p];
                b0 = c[p][4];
`ifdef ARCADE_INPUTS_AUTOFIRE_EN
                if (b0 && autofire_en[p]) begin
                    b0 = ((m_af[p] / AP) % 2) == 0;
                    m_af[p]++;
                end else begin
                    m_af[p] = 0;
                end
`endif
                e.btn[4*(1-p)+3] = ~b0;
                for (int b = 1; b < NB; b++) e.btn[4*(1-p)+3-b] = ~c[p][4+b];
            end
            if (ps2_key[10] != m_tgl) begin
                key_st[ps2_key[7:0]] = ps2_key[9];
                m_tgl = ps2_key[10];
            end
        end
        if (ioctl_wr && ioctl_index == 8'd254 && ioctl_addr < 25'd8) m_dip[ioctl_addr[2:0]] = ioctl_dout;
        for (int i = 0; i < 8; i++) e.dip[8*i +: 8] = m_dip[i];
        exp_q.push_back(e);
    endfunction

    task automatic tick();
        model_step();
        @(negedge clk);
    endtask

    task automatic ticks(int n);
        repeat (n) tick();
    endtask

    task automatic key(logic [7:0] code, bit pressed);
        ps2_key = {~ps2_key[10], pressed, 1'b0, code};
        tick();
    endtask

    task automatic dip_write(logic [24:0] addr, logic [7:0] data);
        ioctl_wr = 1'b1; ioctl_index = 8'd254; ioctl_addr = addr; ioctl_dout = data;
        tick();
        ioctl_wr = 1'b0;
    endtask

    // Monitor: compare every presented output against the queued expectation
    initial begin
        exp_t e;
        int   run = 0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("p_joystick", 64'(p_joystick), 64'(e.joy));
                check("p_buttons", 64'(p_buttons), 64'(e.btn));
                check("start", 64'(start), 64'(e.start));
                check("coin", 64'(coin), 64'(e.coin));
                check("pause", 64'(pause), 64'(e.pause));
                check("dip_sw", dip_sw, e.dip);
            end
            if (reset_n !== 1'b1) begin
                run = 0;
            end else if (coin[0] === 1'b0) begin
                run++;
            end else if (run > 0) begin
                check("coin0_pulse_len", 64'(run), 64'(CH));
                run = 0;
            end
        end
    end

    // Driver: directed scenarios followed by randomized traffic
    initial begin
        for (int i = 0; i < 8; i++) m_dip[i] = 8'h00;
        for (int p = 0; p < 2; p++) begin
            m_coin_left[p] = 0; m_coin_high[p] = 1'b1; m_raw_prev[p] = 1'b0; m_af[p] = 0;
        end
        m_tgl = 1'b0;
        reset_n = 1'b0; ps2_key = 11'h000; joystick = 32'h0; ioctl_wr = 1'b0;
        ioctl_index = 8'h00; ioctl_addr = 25'h0; ioctl_dout = 8'h00;
        coin_lock = 2'b00; autofire_en = 2'b00;
        @(negedge clk);
        ticks(3);
        reset_n = 1'b1;
        ticks(2);

        joystick[15:0] = 16'h0008; tick();
        joystick[15:0] = 16'h0000; ticks(2);

        key(8'h14, 1'b1); ticks(3);
        key(8'h14, 1'b0); ticks(3);
        key(8'h4D, 1'b1); ticks(2);
        key(8'h4D, 1'b0); ticks(2);

        joystick[13] = 1'b1; ticks(3);
        joystick[13] = 1'b0; ticks(12);
        joystick[13] = 1'b1; ticks(2);
        joystick[13] = 1'b0; ticks(2);
        joystick[13] = 1'b1; tick();
        joystick[13] = 1'b0; ticks(12);
        coin_lock = 2'b01;
        joystick[13] = 1'b1; ticks(2);
        joystick[13] = 1'b0; ticks(3);
        joystick[13] = 1'b1; tick();
        coin_lock = 2'b00; ticks(14);
        joystick[13] = 1'b0; ticks(12);
        joystick[13] = 1'b1; tick();
        coin_lock = 2'b01; joystick[13] = 1'b0; ticks(11);
        coin_lock = 2'b00;
        joystick[13] = 1'b1; tick();
        joystick[13] = 1'b0; ticks(5);
        reset_n = 1'b0; tick();
        reset_n = 1'b1; ticks(3);

        dip_write(25'd0, 8'hA5);
        dip_write(25'd1, 8'h3C);
        dip_write(25'd2, 8'hFF);
        dip_write(25'd9, 8'h11);
        tick();
        reset_n = 1'b0; ticks(2);
        reset_n = 1'b1; ticks(2);
        check("dip_low_bytes", 64'(dip_sw[23:0]), 64'h0000_0000_00FF_3CA5);
        check("dip_high_bytes", 64'(dip_sw[63:24]), 64'h0);

        autofire_en = 2'b01; joystick[4] = 1'b1; ticks(20);
        joystick[4] = 1'b0; ticks(2);
        autofire_en = 2'b10; key(8'h14, 1'b1); ticks(3);
        joystick[20] = 1'b1; ticks(12);
        joystick[20] = 1'b0; key(8'h14, 1'b0); ticks(2);
        autofire_en = 2'b00;
        key(8'h36, 1'b1); ticks(2);
        key(8'h36, 1'b0); ticks(12);

        for (int n = 0; n < 3000; n++) begin
            reset_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            for (int p = 0; p < 2; p++) joystick[16*p +: 16] = 16'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 3) == 0) begin
                ps2_key = {~ps2_key[10], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           codes[$urandom_range(0, 14)]};
            end else begin
                ps2_key = {ps2_key[10], 10'($urandom)};
            end
            if ($urandom_range(0, 15) == 0) coin_lock = 2'($urandom);
            if ($urandom_range(0, 31) == 0) autofire_en = 2'($urandom);
            ioctl_wr    = ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0;
            ioctl_index = ($urandom_range(0, 1) == 0) ? 8'd254 : 8'd253;
            ioctl_addr  = 25'($urandom_range(0, 15));
            ioctl_dout  = 8'($urandom);
            tick();
        end

        ioctl_wr = 1'b0; reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("queue_drain", 64'(exp_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arcade_inputs.md
ARCADE_INPUTS -- requirements
Module: arcade_inputs

Interface
- REQ-001: Parameter NUM_PLAYERS, default 2, number of player channels (1..4).
- REQ-002: Parameter NUM_BUTTONS, default 4, fire buttons per player (1..8).
- REQ-003: Parameter DIP_BYTES, default 8, number of DIP switch bytes (1..8).
- REQ-004: Parameter COIN_HOLD, default 1600000, coin pulse length in CLK_32M cycles (50 ms at 32 MHz).
- REQ-005: Parameter AUTOFIRE_PERIOD, default 2133333, autofire half-period in cycles.
- REQ-006: CLK_32M  in  1  sole clock; one clock, reset is synchronous and active-low.
- REQ-007: reset_n  in  1  synchronous active-low reset.
- REQ-008: ps2_key  in  11  [10] event toggle, [9] pressed, [7:0] scan code.
- REQ-009: joystick  in  16*NUM_PLAYERS  per-player HPS pad word, active-high.
- REQ-010: ioctl_wr / ioctl_index / ioctl_addr / ioctl_dout  in  1/8/25/8  HPS download bus.
- REQ-011: coin_lock  in  NUM_PLAYERS  high blocks new coin pulses for that player.
- REQ-012: autofire_en  in  NUM_PLAYERS  per-player autofire request on button 0.
- REQ-013: p_joystick  out  4*NUM_PLAYERS  active-low {up,down,left,right} per player.
- REQ-014: p_buttons  out  NUM_BUTTONS*NUM_PLAYERS  active-low, button 0 at MSB of each field.
- REQ-015: start, coin  out  NUM_PLAYERS each  active-low.
- REQ-016: pause  out  1  active-high.
- REQ-017: dip_sw  out  8*DIP_BYTES  raw DIP bytes, byte 0 in LSBs.

Function
- REQ-018: Pad bit map per player: [0] right, [1] left, [2] down, [3] up, [4+b] button b, [12] start, [13] coin, [14] pause.
- REQ-019: Key event accepted only on the cycle ps2_key[10] differs from its registered previous value; the held state is set to ps2_key[9].
- REQ-020: Key map, player 1 only: 0x75 up, 0x72 down, 0x6B left, 0x74 right, 0x14/0x11/0x29/0x12 buttons 0..3, 0x16 start1, 0x2E coin1, 0x4D pause; player 2, if present: 0x1E start2, 0x36 coin2; unmapped codes are ignored.
- REQ-021: Each control is the OR of its key state and pad bit; outputs are registered; pad-to-output latency is 1 cycle; key-toggle-to-output latency is 2 cycles.
- REQ-022: Pause is the OR of the 0x4D key and bit 14 of every pad.
- REQ-023: Coin per player is a two-state FSM IDLE/HOLD. IDLE->HOLD on the rising edge of raw coin with coin_lock low, loading COIN_HOLD; HOLD decrements the counter and returns to IDLE at 0; coin is asserted (low) for exactly COIN_HOLD cycles.
- REQ-024: A coin edge arriving in HOLD is dropped and does not extend the pulse; a raw coin already held on leaving HOLD produces no new pulse until released.
- REQ-025: coin_lock rising during HOLD does not truncate the pulse in progress.
- REQ-026: Counter width is clog2(COIN_HOLD+1); COIN_HOLD=0 disables coin output (always high).
- REQ-027: DIP write: ioctl_wr and ioctl_index==254 and ioctl_addr<DIP_BYTES stores ioctl_dout into byte ioctl_addr[2:0]; other addresses are ignored.

Reset
- REQ-028: On reset_n low at a clock edge: all key states, coin FSMs (IDLE, counter 0), and autofire phases clear; p_joystick, p_buttons, start and coin go all-ones; pause goes 0.
- REQ-029: DIP registers are not affected by reset (power-up value 0), so OSD reset keeps settings.
- REQ-030: Reset asserted during a coin HOLD aborts the pulse; the next cycle coin is high.

Configuration
- REQ-031: Macro ARCADE_INPUTS_AUTOFIRE_EN: when defined, with autofire_en[i] high and button 0 held, button 0 output toggles every AUTOFIRE_PERIOD cycles, starting asserted; the phase counter clears on release.
- REQ-032: When ARCADE_INPUTS_AUTOFIRE_EN is undefined, autofire_en is ignored and button 0 passes through per REQ-021.

Verification
- REQ-033: Pad P1 = 0x0008 -> p_joystick[7:4] = 4'b0111 one cycle later; release -> 4'b1111.
- REQ-034: ps2_key toggled with code 0x14, pressed=1 -> P1 button 0 low 2 cycles later; toggle with pressed=0 -> high.
- REQ-035: COIN_HOLD=10: P1 pad bit 13 high for 3 cycles -> coin[0] low exactly 10 cycles; second edge at cycle 5 -> still 10 total; coin_lock=1 -> no pulse.
- REQ-036: ioctl_index=254, addr 0..2 written 0xA5,0x3C,0xFF, addr 9 written 0x11 -> dip_sw[23:0] = 0xFF3CA5, no other change; then pulse reset_n -> dip_sw unchanged.
- REQ-037: Reset mid-HOLD at count 4 -> coin high next cycle, FSM IDLE.
- REQ-038: With macro, AUTOFIRE_PERIOD=4, button 0 held, autofire_en=1 -> button low 4, high 4, repeating; without macro -> constant low.
